ldpc_cnu_scheduler: RTL and testbench

// - Sequences the 6-input min-sign check-node unit (CNU) over a flooding-schedule LDPC decode.
// - Issues one check row per cycle: LLR memory read, then CNU input valid, then delayed write-back.
// - Repeats iterations until max count, early-stop or abort; start/busy/done handshake to frame ctrl.

---
 rtl/ldpc_pkg.sv | 15 +
 rtl/ldpc_delay_line.sv | 43 ++++
 rtl/ldpc_cnu_scheduler.sv | 155 +++++++++++++++
 tb/tb_ldpc_cnu_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and default latencies for the LDPC check-node scheduler slice.
package ldpc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ITER_END,
        DONE
    } sched_state_e;

    localparam int DEF_RD_LATENCY  = 1;
    localparam int DEF_CNU_LATENCY = 5;

endpackage

// File: rtl/ldpc_delay_line.sv
// Resettable valid+data shift register with one early valid tap and an "anything in flight" flag.
module ldpc_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6,
    parameter int TAP   = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_tap_valid,
    output logic             o_any_valid
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    // NOTE: the data stages are reset along with the valids so a mid-decode reset
    // leaves no stale address on o_data; this only works because the line is flops, not RAM.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid     = r_valid[DEPTH-1];
    assign o_data      = r_data[DEPTH-1];
    assign o_tap_valid = r_valid[TAP-1];
    assign o_any_valid = |r_valid;

endmodule

// File: rtl/ldpc_cnu_scheduler.sv
// Flooding-schedule sequencer for the 6-input min-sign CNU: issues one check row per cycle,
// tracks reads through the memory+CNU latency, and repeats iterations until a stop condition.
module ldpc_cnu_scheduler
    import ldpc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ITER_W      = 5,
    parameter int RD_LATENCY  = DEF_RD_LATENCY,
    parameter int CNU_LATENCY = DEF_CNU_LATENCY
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_rows,
    input  logic [ITER_W-1:0] i_max_iter,
    input  logic              i_stall,
    input  logic              i_early_stop,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [ITER_W-1:0] o_iter_used,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_cnu_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam int DL_DEPTH = RD_LATENCY + CNU_LATENCY;

    sched_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_num_rows;
    logic [ADDR_W-1:0] r_row;
    logic [ITER_W-1:0] r_max_iter;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [ITER_W-1:0] r_iter_used;
    logic              r_abort_flag;
    logic              r_aborted;

    logic              w_rd_en;
    logic              w_last_row;
    logic              w_finish;
    logic              w_any_valid;
    logic [ITER_W-1:0] w_iter_next;

    assign w_last_row  = (r_row == r_num_rows - ADDR_W'(1));
    assign w_iter_next = r_iter_cnt + ITER_W'(1);
    // An abort arriving in the ITER_END cycle itself still ends the decode.
    assign w_finish    = r_abort_flag | i_abort | i_early_stop | (w_iter_next == r_max_iter);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_rows == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (i_abort) begin
                    w_state_nxt = DRAIN;
                end else if (!i_stall) begin
                    w_rd_en = 1'b1;
                    if (w_last_row) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!w_any_valid) begin
                    w_state_nxt = ITER_END;
                end
            end
            ITER_END: w_state_nxt = w_finish ? DONE : ISSUE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_num_rows   <= '0;
            r_row        <= '0;
            r_max_iter   <= '0;
            r_iter_cnt   <= '0;
            r_iter_used  <= '0;
            r_abort_flag <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_num_rows   <= i_num_rows;
                        r_max_iter   <= (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
                        r_row        <= '0;
                        r_iter_cnt   <= '0;
                        r_iter_used  <= '0;
                        r_abort_flag <= 1'b0;
                        r_aborted    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (i_abort) begin
                        r_abort_flag <= 1'b1;
                    end else if (w_rd_en) begin
                        r_row <= w_last_row ? '0 : r_row + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (i_abort) begin
                        r_abort_flag <= 1'b1;
                    end
                end
                ITER_END: begin
                    r_iter_cnt   <= w_iter_next;
                    r_iter_used  <= w_iter_next;
                    r_abort_flag <= r_abort_flag | i_abort;
                    r_aborted    <= r_abort_flag | i_abort;
                end
                default: begin
                end
            endcase
        end
    end

    ldpc_delay_line #(
        .WIDTH (ADDR_W),
        .DEPTH (DL_DEPTH),
        .TAP   (RD_LATENCY)
    ) u_delay_line (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_valid     (w_rd_en),
        .i_data      (o_rd_addr),
        .o_valid     (o_wr_en),
        .o_data      (o_wr_addr),
        .o_tap_valid (o_cnu_valid),
        .o_any_valid (w_any_valid)
    );

    assign o_rd_en     = w_rd_en;
    assign o_rd_addr   = w_rd_en ? r_row : '0;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_aborted   = r_aborted;
    assign o_iter_used = r_iter_used;

endmodule

// File: tb/tb_ldpc_cnu_scheduler.sv
// Directed bench for ldpc_cnu_scheduler: a read-order/latency scoreboard checked every cycle
// plus literal expectations for iteration count, abort status and timing.
module tb_ldpc_cnu_scheduler;

    localparam int ADDR_W = 8;
    localparam int ITER_W = 5;
    localparam int LAT    = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              early = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] num_rows = '0;
    logic [ITER_W-1:0] max_iter = '0;

    logic              o_busy, o_done, o_aborted, o_rd_en, o_cnu_valid, o_wr_en;
    logic [ITER_W-1:0] o_iter_used;
    logic [ADDR_W-1:0] o_rd_addr, o_wr_addr;

    ldpc_cnu_scheduler #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_num_rows   (num_rows),
        .i_max_iter   (max_iter),
        .i_stall      (stall),
        .i_early_stop (early),
        .i_abort      (abort),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_aborted    (o_aborted),
        .o_iter_used  (o_iter_used),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .o_cnu_valid  (o_cnu_valid),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard state: expected read order and a short history of observed reads.
    int                cyc = 8;
    logic              hist_en   [8];
    logic [ADDR_W-1:0] hist_addr [8];
    int                exp_rd[$];
    int                rd_cyc_q[$];
    int                wr_count = 0;
    int                done_cnt = 0;
    int                last_iter = 0;
    int                last_abort = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                hist_en[i]   = 1'b0;
                hist_addr[i] = '0;
            end
        end else begin
            check("cnu_valid_latency", o_cnu_valid, hist_en[(cyc - 1) % 8]);
            check("wr_en_latency", o_wr_en, hist_en[(cyc - LAT) % 8]);
            if (o_wr_en) begin
                check("wr_addr", o_wr_addr, hist_addr[(cyc - LAT) % 8]);
                wr_count++;
            end
            if (o_rd_en) begin
                if (exp_rd.size() == 0) check("rd_unexpected", o_rd_en, 0);
                else check("rd_addr", o_rd_addr, exp_rd.pop_front());
                rd_cyc_q.push_back(cyc);
            end
            if (o_done) begin
                check("busy_with_done", o_busy, 1);
                done_cnt++;
                last_iter  = o_iter_used;
                last_abort = o_aborted;
            end
            hist_en[cyc % 8]   = o_rd_en;
            hist_addr[cyc % 8] = o_rd_addr;
        end
        cyc++;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_aborted"}, o_aborted, 0);
        check({tag, "_iter_used"}, o_iter_used, 0);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_cnu_valid"}, o_cnu_valid, 0);
        check({tag, "_wr_en"}, o_wr_en, 0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
    endtask

    // Model: reads are rows 0..rows-1 once per iteration; iterations = max(max_iter,1), or 1
    // with early stop; an abort on ISSUE cycle k leaves only the k-1 reads already made.
    task automatic load_model(input int rows, input int miter, input bit es, input int ab_k);
        int iters;
        iters = (rows == 0) ? 0 : (es ? 1 : ((miter == 0) ? 1 : miter));
        if (ab_k > 0) begin
            for (int r = 0; r < rows && r < ab_k - 1; r++) exp_rd.push_back(r);
        end else begin
            for (int it = 0; it < iters; it++)
                for (int r = 0; r < rows; r++) exp_rd.push_back(r);
        end
    endtask

    task automatic run(input string tag, input int rows, input int miter, input bit es,
                       input int st_lo, input int st_hi, input int ab_k,
                       input int exp_iter, input int exp_ab, input int exp_reads,
                       input int exp_done_k);
        int d0, w0, done_k;
        bit seen;
        d0 = done_cnt;
        w0 = wr_count;
        done_k = 0;
        seen = 1'b0;
        rd_cyc_q.delete();
        load_model(rows, miter, es, ab_k);
        @(posedge clk); #1;
        num_rows = ADDR_W'(rows);
        max_iter = ITER_W'(miter);
        early = es;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            stall = (k >= st_lo && k <= st_hi);
            abort = (k == ab_k);
            @(negedge clk); #1;
            if (done_cnt != d0) begin
                seen = 1'b1;
                done_k = k;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        abort = 1'b0;
        early = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_after_done"}, o_busy, 0);
        if (exp_done_k > 0) check({tag, "_done_cycle"}, done_k, exp_done_k);
        repeat (8) @(negedge clk);
        #1;
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_iter_used"}, last_iter, exp_iter);
        check({tag, "_aborted"}, last_abort, exp_ab);
        check({tag, "_read_count"}, rd_cyc_q.size(), exp_reads);
        check({tag, "_write_count"}, wr_count - w0, exp_reads);
        check({tag, "_reads_left"}, exp_rd.size(), 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        #10 rst_n = 1'b1;

        run("basic", 4, 2, 1'b0, 0, 0, 0, 2, 0, 8, 0);
        run("early_stop", 3, 5, 1'b1, 0, 0, 0, 1, 0, 3, 0);
        run("stall", 8, 1, 1'b0, 3, 5, 0, 1, 0, 8, 0);
        if (rd_cyc_q.size() == 8) begin
            check("stall_gap", rd_cyc_q[2] - rd_cyc_q[1], 4);
            check("stall_span", rd_cyc_q[7] - rd_cyc_q[0], 10);
        end
        run("abort", 4, 3, 1'b0, 0, 0, 3, 1, 1, 2, 0);
        run("zero_rows", 0, 3, 1'b0, 0, 0, 0, 0, 0, 0, 1);
        run("max_iter0", 2, 0, 1'b0, 0, 0, 0, 1, 0, 2, 0);

        // Reset in the middle of DRAIN: reads on ISSUE cycles 1-4, writes would start on cycle 7.
        begin
            int w0;
            w0 = wr_count;
            load_model(4, 1, 1'b0, 0);
            @(posedge clk); #1;
            num_rows = 8'd4;
            max_iter = 5'd1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (5) @(posedge clk);
            #3 rst_n = 1'b0;
            #1 check_all_zero("async_reset");
            exp_rd.delete();
            repeat (3) @(posedge clk);
            #3 rst_n = 1'b1;
            repeat (10) @(negedge clk);
            #1 check("no_wr_after_reset", wr_count - w0, 0);
        end
        run("after_reset", 4, 1, 1'b0, 0, 0, 0, 1, 0, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
